// File: rtl/dram_responder.sv
// dram_responder
//   Memory-side responder for the TOM DRAM strobe interface. Decodes the
//   RAS/CAS/WE/OE strobes into single 64-bit word requests for the SDRAM
//   backend, returns read data toward TOM and signals completion on ram_rdy.
//
// Ports
//   sys_clk, xresetl         clock, asynchronous active-low reset
//   xrasl[1:0], xcasl[1:0]   active-low RAS per bank / CAS strobes
//   xma                      multiplexed row/column address
//   xwel[7:0]                active-low byte write enables
//   xoel[2:0]                active-low output enables (bit 0 gates read drive)
//   xd_out                   write data from TOM
//   xd_in, xd_oe             read data toward TOM and its per-bit drive enables
//   ram_rdy                  data valid / write accepted
//   mem_req/we/addr/be/wdata backend request, held stable until mem_ack
//   mem_rdata, mem_ack       backend read data and one-cycle completion pulse
//   refresh                  one-cycle pulse per CAS-before-RAS cycle
//   proto_err                sticky protocol error flag
module dram_responder #(
    parameter int ROW_W = 11,
    parameter int COL_W = 10
) (
    input  logic                   sys_clk,
    input  logic                   xresetl,
    input  logic [1:0]             xrasl,
    input  logic [1:0]             xcasl,
    input  logic [ROW_W-1:0]       xma,
    input  logic [7:0]             xwel,
    input  logic [2:0]             xoel,
    input  logic [63:0]            xd_out,
    output logic [63:0]            xd_in,
    output logic [63:0]            xd_oe,
    output logic                   ram_rdy,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ROW_W+COL_W:0]   mem_addr,
    output logic [7:0]             mem_be,
    output logic [63:0]            mem_wdata,
    input  logic [63:0]            mem_rdata,
    input  logic                   mem_ack,
    output logic                   refresh,
    output logic                   proto_err
);

    typedef enum logic [2:0] {IDLE, REFR, ROWOPEN, REQ, DATA} state_t;

    state_t state_q, state_d;

    logic [1:0]       ras_q, ras_qq, cas_q, cas_qq;
    logic [ROW_W-1:0] xma_q;
    logic [7:0]       xwel_q;
    logic [63:0]      xd_out_q;
    logic             bank_q;
    logic [ROW_W-1:0] row_q;
    logic             abort_q;

    logic [1:0] ras_fall, ras_rise;
    logic       cas_fall_any, cas_rise_any, bank_ras_high;
    logic       open_row, start_cbr, latch_cas, take_ack, set_err, abort_now;

    // Only xoel[0] participates in DRAM read drive.
    logic unused_oel;
    assign unused_oel = &{1'b0, xoel[2:1]};

    // Edges are taken between two registered copies, so the address, write
    // enables and data are registered alongside to stay aligned with them.
    assign ras_fall      = ras_qq & ~ras_q;
    assign ras_rise      = ~ras_qq & ras_q;
    assign cas_fall_any  = |(cas_qq & ~cas_q);
    assign cas_rise_any  = |(~cas_qq & cas_q);
    assign bank_ras_high = ras_q[bank_q];

    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) begin
            ras_q    <= '1;
            ras_qq   <= '1;
            cas_q    <= '1;
            cas_qq   <= '1;
            xma_q    <= '0;
            xwel_q   <= '1;
            xd_out_q <= '0;
        end else begin
            ras_q    <= xrasl;
            ras_qq   <= ras_q;
            cas_q    <= xcasl;
            cas_qq   <= cas_q;
            xma_q    <= xma;
            xwel_q   <= xwel;
            xd_out_q <= xd_out;
        end
    end

    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        open_row  = 1'b0;
        start_cbr = 1'b0;
        latch_cas = 1'b0;
        take_ack  = 1'b0;
        set_err   = 1'b0;
        abort_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (|ras_fall) begin
                    if (!(&cas_q)) begin
                        start_cbr = 1'b1;
                        state_d   = REFR;
                    end else begin
                        open_row = 1'b1;
                        set_err  = &ras_fall;
                        state_d  = ROWOPEN;
                    end
                end
            end
            REFR: begin
                if (&ras_q) state_d = IDLE;
            end
            ROWOPEN: begin
                if (bank_ras_high) begin
                    state_d = IDLE;
                end else if (cas_fall_any) begin
                    latch_cas = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // A strobe release mid-request never cancels the backend
                // access; it only suppresses the ram_rdy handshake.
                abort_now = cas_rise_any | ras_rise[bank_q];
                set_err   = abort_now;
                if (mem_ack) begin
                    take_ack = 1'b1;
                    if (abort_q || abort_now)
                        state_d = bank_ras_high ? IDLE : ROWOPEN;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (&cas_q) state_d = bank_ras_high ? IDLE : ROWOPEN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge xresetl) begin
        if (!xresetl) begin
            bank_q    <= 1'b0;
            row_q     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            xd_in     <= '0;
            refresh   <= 1'b0;
            proto_err <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            refresh <= start_cbr;
            if (set_err) proto_err <= 1'b1;
            if (open_row) begin
                bank_q <= ~ras_fall[0];
                row_q  <= xma_q;
            end
            if (latch_cas) begin
                mem_addr  <= {bank_q, row_q, xma_q[COL_W-1:0]};
                mem_we    <= ~(&xwel_q);
                mem_be    <= ~xwel_q;
                mem_wdata <= xd_out_q;
                abort_q   <= 1'b0;
            end else if (abort_now) begin
                abort_q <= 1'b1;
            end
            if (take_ack && !mem_we) xd_in <= mem_rdata;
        end
    end

    assign mem_req = (state_q == REQ);
    assign ram_rdy = (state_q == DATA);
    assign xd_oe   = (state_q == DATA && !mem_we && !xoel[0]) ? '1 : '0;

endmodule

// File: tb/tb_dram_responder.sv
module tb_dram_responder;

    logic        sys_clk = 1'b0;
    logic        xresetl;
    logic [1:0]  xrasl, xcasl;
    logic [10:0] xma;
    logic [7:0]  xwel;
    logic [2:0]  xoel;
    logic [63:0] xd_out, xd_in, xd_oe, mem_wdata, mem_rdata;
    logic        ram_rdy, mem_req, mem_we, mem_ack, refresh, proto_err;
    logic [21:0] mem_addr;
    logic [7:0]  mem_be;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    dram_responder #(.ROW_W(11), .COL_W(10)) dut (
        .sys_clk(sys_clk), .xresetl(xresetl), .xrasl(xrasl), .xcasl(xcasl),
        .xma(xma), .xwel(xwel), .xoel(xoel), .xd_out(xd_out), .xd_in(xd_in),
        .xd_oe(xd_oe), .ram_rdy(ram_rdy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .refresh(refresh),
        .proto_err(proto_err)
    );

    typedef struct {
        logic        bank;
        logic [10:0] row;
        logic [9:0]  col;
        logic [7:0]  xwel;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        oe0;
        int unsigned wt;
        logic [21:0] e_addr;
        logic        e_we;
        logic [7:0]  e_be;
        logic [63:0] e_oe;
        logic [63:0] e_xdin;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #2;
    endtask

    task automatic open_row(input logic bank, input logic [10:0] row);
        xma   = row;
        xrasl = bank ? 2'b01 : 2'b10;
        tick; tick; tick;
        xma = 11'($urandom);
    endtask

    task automatic close_row;
        xrasl = 2'b11;
        tick; tick; tick;
    endtask

    // One CAS cycle with a backend that acks v.wt cycles after the first
    // cycle in which it can observe mem_req.
    task automatic cas_cycle(input vec_t v);
        xma    = {1'b0, v.col};
        xwel   = v.xwel;
        xd_out = v.wd;
        xoel   = {2'b11, v.oe0};
        xcasl  = 2'b00;
        tick;
        chk("req_early", 64'(mem_req), 64'(1'b0));
        tick;
        chk("req_assert", 64'(mem_req), 64'(1'b1));
        chk("addr", 64'(mem_addr), 64'(v.e_addr));
        chk("we", 64'(mem_we), 64'(v.e_we));
        chk("be", 64'(mem_be), 64'(v.e_be));
        chk("wdata", mem_wdata, v.wd);
        xma    = 11'($urandom);
        xwel   = 8'hFF;
        xd_out = {$urandom, $urandom};
        for (int unsigned i = 0; i < v.wt; i++) begin
            tick;
            chk("req_hold", 64'(mem_req), 64'(1'b1));
        end
        tick;
        chk("rdy_before_ack", 64'(ram_rdy), 64'(1'b0));
        chk("addr_stable", 64'(mem_addr), 64'(v.e_addr));
        mem_ack   = 1'b1;
        mem_rdata = v.rd;
        tick;
        mem_ack   = 1'b0;
        mem_rdata = {$urandom, $urandom};
        chk("rdy_after_ack", 64'(ram_rdy), 64'(1'b1));
        chk("req_drop", 64'(mem_req), 64'(1'b0));
        chk("oe", xd_oe, v.e_oe);
        chk("xd_in", xd_in, v.e_xdin);
        tick;
        chk("rdy_hold", 64'(ram_rdy), 64'(1'b1));
        chk("xd_in_hold", xd_in, v.e_xdin);
        xcasl = 2'b11;
        tick;
        chk("rdy_cas_sampled", 64'(ram_rdy), 64'(1'b1));
        tick;
        chk("rdy_fall", 64'(ram_rdy), 64'(1'b0));
        chk("oe_fall", xd_oe, 64'h0);
        chk("no_err", 64'(proto_err), 64'(1'b0));
    endtask

    vec_t        vecs[4];
    vec_t        pv;
    logic [63:0] model_xdin;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        xresetl = 1'b0; xrasl = 2'b11; xcasl = 2'b11; xma = '0; xwel = 8'hFF;
        xoel = 3'b111; xd_out = '0; mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        tick; tick;
        chk("rst_xd_in", xd_in, 64'h0);
        chk("rst_xd_oe", xd_oe, 64'h0);
        chk("rst_rdy", 64'(ram_rdy), 64'(1'b0));
        chk("rst_req", 64'(mem_req), 64'(1'b0));
        chk("rst_we", 64'(mem_we), 64'(1'b0));
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_be", 64'(mem_be), 64'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        chk("rst_refresh", 64'(refresh), 64'(1'b0));
        chk("rst_err", 64'(proto_err), 64'(1'b0));
        xresetl = 1'b1;
        tick; tick;

        // Directed vectors: zero-wait read, byte write, gated read, top-byte write
        vecs[0] = '{1'b0, 11'h123, 10'h045, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 1'b0, 0,
                    22'h048C45, 1'b0, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF};
        vecs[1] = '{1'b1, 11'h7FF, 10'h3FF, 8'hF0, 64'hAA55, 64'hDEAD, 1'b0, 2,
                    22'h3FFFFF, 1'b1, 8'h0F, 64'h0, 64'h0123456789ABCDEF};
        vecs[2] = '{1'b1, 11'h000, 10'h000, 8'hFF, 64'h0, 64'hFEDCBA9876543210, 1'b1, 1,
                    22'h200000, 1'b0, 8'h00, 64'h0, 64'hFEDCBA9876543210};
        vecs[3] = '{1'b0, 11'h555, 10'h2AA, 8'h7F, 64'h1122334455667788, 64'h5A5A, 1'b0, 0,
                    22'h1556AA, 1'b1, 8'h80, 64'h0, 64'hFEDCBA9876543210};
        for (int i = 0; i < 4; i++) begin
            open_row(vecs[i].bank, vecs[i].row);
            cas_cycle(vecs[i]);
            close_row;
        end

        // Page mode: three reads under one RAS
        open_row(1'b0, 11'h2A5);
        for (int i = 1; i <= 3; i++) begin
            pv = '{1'b0, 11'h2A5, 10'(i), 8'hFF, 64'h0, 64'hA0 + 64'(i), 1'b0, unsigned'(i - 1),
                   {1'b0, 11'h2A5, 10'(i)}, 1'b0, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'hA0 + 64'(i)};
            cas_cycle(pv);
        end
        close_row;
        chk("page_no_err", 64'(proto_err), 64'(1'b0));
        model_xdin = 64'hA3;

        // CBR refresh
        xcasl = 2'b00;
        tick; tick;
        xrasl = 2'b10;
        tick;
        chk("cbr_early", 64'(refresh), 64'(1'b0));
        tick;
        chk("cbr_pulse", 64'(refresh), 64'(1'b1));
        chk("cbr_no_req", 64'(mem_req), 64'(1'b0));
        tick;
        chk("cbr_one_cycle", 64'(refresh), 64'(1'b0));
        chk("cbr_no_req2", 64'(mem_req), 64'(1'b0));
        xrasl = 2'b11; xcasl = 2'b11;
        tick; tick; tick;
        chk("cbr_no_err", 64'(proto_err), 64'(1'b0));

        // Randomised traffic against the request/response model
        for (int r = 0; r < 25; r++) begin
            logic        bank;
            logic [10:0] row;
            bank = 1'($urandom_range(0, 1));
            row  = 11'($urandom);
            open_row(bank, row);
            for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
                pv.bank = bank;
                pv.row  = row;
                pv.col  = 10'($urandom);
                pv.xwel = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                pv.wd   = {$urandom, $urandom};
                pv.rd   = {$urandom, $urandom};
                pv.oe0  = 1'($urandom_range(0, 1));
                pv.wt   = $urandom_range(0, 3);
                pv.e_addr = {bank, row, pv.col};
                pv.e_we   = (pv.xwel != 8'hFF);
                pv.e_be   = ~pv.xwel;
                pv.e_oe   = (!pv.e_we && !pv.oe0) ? 64'hFFFFFFFFFFFFFFFF : 64'h0;
                if (!pv.e_we) model_xdin = pv.rd;
                pv.e_xdin = model_xdin;
                cas_cycle(pv);
            end
            close_row;
        end

        // Aborted cycle: CAS released while the backend withholds ack
        open_row(1'b0, 11'h100);
        xma = 11'h005; xwel = 8'hFF; xoel = 3'b110; xcasl = 2'b00;
        tick; tick;
        chk("abort_req", 64'(mem_req), 64'(1'b1));
        xcasl = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("abort_req_hold", 64'(mem_req), 64'(1'b1));
            chk("abort_no_rdy", 64'(ram_rdy), 64'(1'b0));
        end
        mem_ack = 1'b1; mem_rdata = 64'h77;
        tick;
        mem_ack = 1'b0;
        chk("abort_req_drop", 64'(mem_req), 64'(1'b0));
        chk("abort_no_rdy_ack", 64'(ram_rdy), 64'(1'b0));
        chk("abort_err", 64'(proto_err), 64'(1'b1));
        tick;
        chk("abort_no_rdy_late", 64'(ram_rdy), 64'(1'b0));
        close_row;
        chk("abort_err_sticky", 64'(proto_err), 64'(1'b1));

        // Reset mid-request
        open_row(1'b1, 11'h0AA);
        xma = 11'h011; xcasl = 2'b00;
        tick; tick;
        chk("mid_req", 64'(mem_req), 64'(1'b1));
        #1 xresetl = 1'b0;
        #1;
        chk("mid_rst_req", 64'(mem_req), 64'(1'b0));
        chk("mid_rst_rdy", 64'(ram_rdy), 64'(1'b0));
        chk("mid_rst_addr", 64'(mem_addr), 64'h0);
        chk("mid_rst_err", 64'(proto_err), 64'(1'b0));
        chk("mid_rst_xd_in", xd_in, 64'h0);
        xrasl = 2'b11; xcasl = 2'b11;
        tick;
        xresetl = 1'b1;
        tick;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        chk("late_ack_no_rdy", 64'(ram_rdy), 64'(1'b0));
        chk("late_ack_no_req", 64'(mem_req), 64'(1'b0));
        tick;
        chk("late_ack_no_rdy2", 64'(ram_rdy), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
# dram_responder

Memory-side responder for the TOM DRAM strobe interface. It decodes xrasl/xcasl/xma/xwel/xoel into single 64-bit word requests for the SDRAM backend. For reads it drives xd_in-side data back toward TOM and asserts ram_rdy so TOM can time the CAS cycle; for writes it forwards data and byte enables. It sits between the TOM pin bus and the SDRAM controller in the console top level, on the sys_clk domain.

## Interface
- ROW_W, 11: row address width taken from xma.
- COL_W, 10: column width, xma[COL_W-1:0].
- sys_clk  in  1  system clock; all strobes arrive synchronous to it.
- xresetl  in  1  asynchronous active-low reset.
- xrasl  in  2  active-low RAS per bank.
- xcasl  in  2  active-low CAS; a cycle starts when either bit is low.
- xma  in  11  multiplexed row/column address.
- xwel  in  8  active-low byte write enables.
- xoel  in  3  active-low output enables; only xoel[0] gates DRAM read drive.
- xd_out  in  64  write data from TOM.
- xd_in  out  64  read data toward TOM.
- xd_oe  out  64  per-bit drive enables; all bits are always equal.
- ram_rdy  out  1  data valid / write accepted, to TOM.
- mem_req  out  1  backend request.
- mem_we  out  1  1 = write.
- mem_addr  out  1+ROW_W+COL_W  {bank, row, col}.
- mem_be  out  8  byte enables, ~xwel at CAS sample.
- mem_wdata  out  64  write data.
- mem_rdata  in  64  backend read data.
- mem_ack  in  1  one-cycle completion pulse.
- refresh  out  1  one-cycle pulse per CAS-before-RAS cycle.
- proto_err  out  1  sticky protocol error flag.

## Operation
- Edge detection uses registered copies of xrasl and xcasl. A fall means the previous value was 1 and the current value is 0.
- FSM states and transitions:
  - IDLE: a RAS fall with both CAS high latches the row (xma[ROW_W-1:0]) and the bank, then goes to ROWOPEN.
    - bank = 0 if xrasl[0] fell, else 1. Simultaneous falls select bank 0 and set proto_err.
    - A RAS fall while any CAS is low is a CBR refresh: pulse refresh, latch no row, go to REFR.
  - REFR: return to IDLE when both RAS are high.
  - ROWOPEN: a CAS fall latches the column and goes to REQ.
    - mem_we = any xwel low, mem_be = ~xwel, mem_wdata = xd_out, mem_addr = {bank, row, col}.
    - If the open bank's RAS rises, go to IDLE.
  - REQ: mem_req is held at 1 with stable fields until mem_ack.
    - On ack, mem_req drops. For reads, mem_rdata is captured into xd_in.
    - Then go to DATA.
  - DATA: ram_rdy = 1.
    - xd_oe = all ones only when the cycle is a read and xoel[0] = 0. Otherwise xd_oe = 0.
    - When both CAS are high: ram_rdy drops, then go to ROWOPEN if RAS is still low, else IDLE. This supports page mode.
- A CAS rise or RAS rise while in REQ does not abort the request. The request completes, proto_err is set, and the FSM returns to IDLE or ROWOPEN per the RAS level without asserting ram_rdy.
- proto_err clears only on reset.

## Timing
- Reset values: all outputs are 0, xd_in = 0, the FSM is in IDLE, and the edge registers are 1. Reset mid-request drops mem_req immediately. A later mem_ack is ignored.
- A CAS fall seen at edge N (registered comparison) produces mem_req = 1 at edge N+1.
- mem_ack at edge M produces ram_rdy = 1 and valid xd_in at edge M+1.
- Minimum read latency from the CAS-fall sample to ram_rdy is 3 cycles, with a zero-wait backend acking in the cycle after mem_req.
- ram_rdy and xd_oe fall one cycle after both CAS are sampled high.
- A mem_ack outside REQ is ignored. mem_req never asserts for two requests back to back without an intervening DATA or abort state.

## Test plan
- Read with a zero-wait backend:
  - Stimulus: xrasl = 2'b10 with xma = 0x123, then xcasl = 2'b00 with xma = 0x045, xwel = 8'hFF, xoel[0] = 0; mem_ack one cycle after mem_req with mem_rdata = 64'h0123456789ABCDEF.
  - Required response: mem_addr = {0, 0x123, 0x045}, mem_we = 0; ram_rdy and xd_oe = all ones 3 cycles after the CAS fall sample; xd_in = 0x0123456789ABCDEF until CAS rises.
- Byte write:
  - Stimulus: bank 1 row 0x7FF, col 0x3FF, xwel = 8'hF0, xd_out = 64'hAA55.
  - Required response: mem_we = 1, mem_be = 8'h0F, mem_addr = {1, 0x7FF, 0x3FF}, xd_oe stays 0, ram_rdy pulses after ack.
- Page mode:
  - Stimulus: three CAS cycles with cols 1, 2, 3 under one RAS.
  - Required response: three requests with the same row; the FSM returns to ROWOPEN between them; no proto_err.
- CBR refresh:
  - Stimulus: xcasl = 0, then xrasl falls.
  - Required response: refresh = 1 for exactly one cycle, mem_req stays 0.
- Aborted cycle:
  - Stimulus: CAS rises while mem_ack is withheld 5 cycles.
  - Required response: mem_req held until ack, ram_rdy never asserts, proto_err = 1 until reset.
- Reset mid-request:
  - Stimulus: drop xresetl while mem_req = 1.
  - Required response: mem_req = 0 and all outputs 0 asynchronously; a subsequent ack produces no ram_rdy.
